// File: rtl/ifmap_pkg.sv
// Shared state encoding and counter-width helper for the ifmap input controller.
package ifmap_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_CONFIG  = 3'd0;
  localparam state_t ST_CHAIN   = 3'd1;
  localparam state_t ST_WRITE   = 3'd2;
  localparam state_t ST_WAIT_SW = 3'd3;
  localparam state_t ST_SWITCH  = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  // Bits needed to count 0..max-1; never below one bit.
  function automatic int cnt_w(input int max);
    return (max <= 2) ? 1 : $clog2(max);
  endfunction

endpackage

// File: rtl/ifmap_input_ctrl_if.sv
// Handshake/config bundle between the ifmap input controller (slave) and its environment (master).
// Optional IFMAP_INPUT_STALL_CNT_EN adds the stall_cnt observation signal.
interface ifmap_input_ctrl_if #(
  parameter int NBANK_W = 8,
  parameter int ADDR_W  = 4
);
  logic               config_en;
  logic [NBANK_W-1:0] num_banks;
  logic               in_valid;
  logic               in_ready;
  logic               read_ready;
  logic               chain_en;
  logic               chain_clr;
  logic               wen;
  logic [ADDR_W-1:0]  waddr;
  logic               switch;
  logic               done;
`ifdef IFMAP_INPUT_STALL_CNT_EN
  logic [31:0]        stall_cnt;
`endif

  modport master (
    output config_en, num_banks, in_valid, read_ready,
    input  in_ready, chain_en, chain_clr, wen, waddr, switch, done
`ifdef IFMAP_INPUT_STALL_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  config_en, num_banks, in_valid, read_ready,
    output in_ready, chain_en, chain_clr, wen, waddr, switch, done
`ifdef IFMAP_INPUT_STALL_CNT_EN
    , output stall_cnt
`endif
  );

endinterface

// File: rtl/ifmap_input_ctrl_wrap_counter.sv
// Up-counter that wraps from MAX-1 to 0; last flags the wrap value.
module wrap_counter
  import ifmap_pkg::*;
#(
  parameter int MAX = 4,
  localparam int W = cnt_w(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         last
);

  localparam logic [W-1:0] TOP = W'(MAX - 1);

  assign last = (count == TOP);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/ifmap_input_ctrl.sv
// Ifmap input sequencer: chains CHAIN_LEN words per buffer word, fills banks, swaps double buffer.
// Optional IFMAP_INPUT_STALL_CNT_EN adds a saturating stall counter.
//
// state      | meaning
// CONFIG     | idle after reset, waiting for config_en
// CHAIN      | accepting input words into the chaining register
// WRITE      | one-cycle write of the chained word, chain register cleared
// WAIT_SW    | bank full, waiting for reader to release the other bank
// SWITCH     | one-cycle double-buffer swap
// DONE       | frame complete, config_en starts a new frame
module ifmap_input_ctrl
  import ifmap_pkg::*;
#(
  parameter int CHAIN_LEN  = 4,
  parameter int BANK_DEPTH = 16,
  parameter int NBANK_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  ifmap_input_ctrl_if.slave bus
);

  localparam int CHAIN_W = cnt_w(CHAIN_LEN);
  localparam int ADDR_W  = cnt_w(BANK_DEPTH);

  state_t               state, state_nxt;
  logic [NBANK_W-1:0]   nbank_q;
  logic                 cfg_acc;
  logic                 hs;
  logic [CHAIN_W-1:0]   chain_cnt;
  logic                 chain_last;
  logic [ADDR_W-1:0]    addr_cnt;
  logic                 addr_last;
  logic [NBANK_W-1:0]   bank_cnt;
  logic                 bank_last;
  logic                 unused_chain;

  assign cfg_acc = ((state == ST_CONFIG) || (state == ST_DONE)) && bus.config_en;
  assign hs      = bus.in_valid && (state == ST_CHAIN);

  wrap_counter #(.MAX(CHAIN_LEN)) u_chain_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (hs),
    .clr   (cfg_acc),
    .count (chain_cnt),
    .last  (chain_last)
  );

  wrap_counter #(.MAX(BANK_DEPTH)) u_addr_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (state == ST_WRITE),
    .clr   (cfg_acc),
    .count (addr_cnt),
    .last  (addr_last)
  );

  wrap_counter #(.MAX(2 ** NBANK_W)) u_bank_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (state == ST_SWITCH),
    .clr   (cfg_acc),
    .count (bank_cnt),
    .last  (bank_last)
  );

  // The chain position only matters through its wrap flag.
  assign unused_chain = ^chain_cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CONFIG, ST_DONE: begin
        if (bus.config_en) state_nxt = (bus.num_banks == '0) ? ST_DONE : ST_CHAIN;
      end
      ST_CHAIN: begin
        if (hs && chain_last) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        state_nxt = addr_last ? ST_WAIT_SW : ST_CHAIN;
      end
      ST_WAIT_SW: begin
        if (bus.read_ready) state_nxt = ST_SWITCH;
      end
      ST_SWITCH: begin
        // A bank counter at its ceiling ends the frame instead of wrapping.
        if ((NBANK_W'(bank_cnt + NBANK_W'(1)) == nbank_q) || bank_last) state_nxt = ST_DONE;
        else state_nxt = ST_CHAIN;
      end
      default: state_nxt = ST_CONFIG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CONFIG;
      nbank_q <= '0;
    end else begin
      state <= state_nxt;
      if (cfg_acc) nbank_q <= bus.num_banks;
    end
  end

  assign bus.in_ready  = (state == ST_CHAIN);
  assign bus.chain_en  = hs;
  assign bus.chain_clr = (state == ST_CONFIG) || (state == ST_WRITE) || (state == ST_DONE);
  assign bus.wen       = (state == ST_WRITE);
  assign bus.waddr     = addr_cnt;
  assign bus.switch    = (state == ST_SWITCH);
  assign bus.done      = (state == ST_DONE);

`ifdef IFMAP_INPUT_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst || cfg_acc) begin
      stall_q <= '0;
    end else if (((state == ST_WAIT_SW) || ((state == ST_CHAIN) && !bus.in_valid))
                 && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`endif

endmodule
